// File: rtl/dsp48a1_seq_pkg.sv
// Shared OPMODE encodings, pipeline depth and stage-tag flags for the
// DSP48A1 multiply-accumulate sequencer.
package dsp48a1_seq_pkg;

    localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0
    localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P
    localparam logic [7:0] OPM_IDLE  = 8'h08;  // X=0, Z=P
    localparam int         PIPE_LAT  = 3;

    // Flag half of the per-term tag; the count field is sized by the top's CNT_W.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_flags_t;

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding {P, term count} results.
module mac_result_fifo #(
    parameter int W     = 56,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_en_i,
    input  logic [W-1:0]                 wr_data_i,
    input  logic                         rd_en_i,
    output logic [W-1:0]                 rd_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          rd_ok, wr_ok;

    assign rd_ok = rd_en_i && (count_q != '0);
    assign wr_ok = wr_en_i && ((count_q != CW'(DEPTH)) || rd_ok);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Empty reads present zero so the result bus is clean out of reset.
    assign empty_o   = (count_q == '0);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Streams (a, b) pairs into a DSP48A1 slice, sequences OPMODE so each frame's
// dot product accumulates in P, and queues {P, count} per frame.
module dsp48a1_mac_sequencer
    import dsp48a1_seq_pkg::*;
#(
    parameter int RES_DEPTH = 4,
    parameter int CNT_W     = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [17:0]       S_A,
    input  logic [17:0]       S_B,
    input  logic              S_LAST,
    output logic [17:0]       DSP_A,
    output logic [17:0]       DSP_B,
    output logic [7:0]        DSP_OPMODE,
    output logic              DSP_RST,
    input  logic [47:0]       DSP_P,
    output logic              R_VALID,
    input  logic              R_READY,
    output logic [47:0]       R_DATA,
    output logic [CNT_W-1:0]  R_COUNT
);

    localparam int RW = 48 + CNT_W;
    localparam int FW = $clog2(RES_DEPTH+1);
    localparam int SW = $clog2(RES_DEPTH + PIPE_LAT + 2) + 1;

    typedef struct packed {
        tag_flags_t       f;
        logic [CNT_W-1:0] count;
    } stage_tag_t;

    // Stage 0 rides with DSP_A/DSP_B; stages 1..PIPE_LAT track slice A1/B1, M and P.
    stage_tag_t [PIPE_LAT:0] pipe_q;
    stage_tag_t              tag_d;
    logic [17:0]             dsp_a_q, dsp_b_q;
    logic [7:0]              opm_q;
    logic                    first_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    accept;
    logic [SW-1:0]           lasts_in_flight;
    logic [FW-1:0]           fifo_count;
    logic                    fifo_empty;
    logic [RW-1:0]           fifo_rd_data;

    assign accept = S_VALID && S_READY;

    always_comb begin
        cnt_d = cnt_q;
        if (first_q)              cnt_d = CNT_W'(1);
        else if (cnt_q != '1)     cnt_d = cnt_q + CNT_W'(1);
        tag_d         = '0;
        tag_d.f.valid = accept;
        tag_d.f.first = accept && first_q;
        tag_d.f.last  = accept && S_LAST;
        tag_d.count   = accept ? cnt_d : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dsp_a_q <= '0;
            dsp_b_q <= '0;
            opm_q   <= 8'h00;
            pipe_q  <= '0;
            first_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                dsp_a_q <= S_A;
                dsp_b_q <= S_B;
                cnt_q   <= cnt_d;
                first_q <= S_LAST;
            end
            pipe_q[0] <= tag_d;
            for (int i = 1; i <= PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            // OPMODE is registered alongside the tag entering stage 1.
            if (!pipe_q[0].f.valid)     opm_q <= OPM_IDLE;
            else if (pipe_q[0].f.first) opm_q <= OPM_FIRST;
            else                        opm_q <= OPM_ACC;
        end
    end

    always_comb begin
        lasts_in_flight = '0;
        for (int i = 0; i <= PIPE_LAT; i++)
            lasts_in_flight = lasts_in_flight + SW'(pipe_q[i].f.valid && pipe_q[i].f.last);
    end

    // One FIFO credit is reserved per frame end still in the pipeline.
    assign S_READY = RST_N && ((SW'(fifo_count) + lasts_in_flight) < SW'(RES_DEPTH));

    mac_result_fifo #(
        .W     (RW),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .wr_en_i   (pipe_q[PIPE_LAT].f.valid && pipe_q[PIPE_LAT].f.last),
        .wr_data_i ({DSP_P, pipe_q[PIPE_LAT].count}),
        .rd_en_i   (R_READY),
        .rd_data_o (fifo_rd_data),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign DSP_A      = dsp_a_q;
    assign DSP_B      = dsp_b_q;
    assign DSP_OPMODE = opm_q;
    assign DSP_RST    = !RST_N;
    assign R_VALID    = !fifo_empty;
    assign R_DATA     = fifo_rd_data[RW-1:CNT_W];
    assign R_COUNT    = fifo_rd_data[CNT_W-1:0];

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Directed bench: behavioural DSP48A1 slice (A1/B1, M, OPMODE, P regs) closes the loop.
module tb_dsp48a1_mac_sequencer;

    logic        clk = 1'b0;
    logic        RST_N = 1'b0;
    logic        S_VALID = 1'b0, S_LAST = 1'b0;
    logic [17:0] S_A = '0, S_B = '0;
    logic        S_READY;
    logic [17:0] DSP_A, DSP_B;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_RST;
    logic [47:0] DSP_P;
    logic        R_VALID;
    logic        R_READY = 1'b0;
    logic [47:0] R_DATA;
    logic [7:0]  R_COUNT;

    int errors = 0;
    int checks = 0;

    logic [47:0] rq_data[$];
    logic [7:0]  rq_cnt[$];

    always #5 clk = ~clk;

    dsp48a1_mac_sequencer #(.RES_DEPTH(4), .CNT_W(8)) dut (
        .CLK(clk), .RST_N(RST_N),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B), .S_LAST(S_LAST),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE), .DSP_RST(DSP_RST), .DSP_P(DSP_P),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_COUNT(R_COUNT)
    );

    // Slice model: A1REG/B1REG, MREG, OPMODEREG, PREG, all CE high.
    logic signed [17:0] a1, b1;
    logic signed [35:0] prod;
    logic [47:0]        m_r, p_r, xmux, zmux;
    logic [7:0]         opm_r;
    assign prod  = a1 * b1;
    assign xmux  = (opm_r[1:0] == 2'b01) ? m_r : 48'd0;
    assign zmux  = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
    assign DSP_P = p_r;

    always @(posedge clk) begin
        if (DSP_RST) begin
            a1 <= '0; b1 <= '0; m_r <= '0; p_r <= '0; opm_r <= '0;
        end else begin
            a1    <= DSP_A;
            b1    <= DSP_B;
            m_r   <= {{12{prod[35]}}, prod};
            opm_r <= DSP_OPMODE;
            p_r   <= xmux + zmux;
        end
    end

    // Inputs change at posedge+1, so the negedge sees the values the next edge will use.
    always @(negedge clk) begin
        if (RST_N && R_VALID && R_READY) begin
            rq_data.push_back(R_DATA);
            rq_cnt.push_back(R_COUNT);
        end
    end

    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
        int  n;
        bit  done;
        n = 0; done = 0;
        S_VALID = 1'b1; S_A = a; S_B = b; S_LAST = last;
        while (!done) begin
            @(negedge clk);
            if (S_READY) done = 1;
            @(posedge clk); #1;
            if (!done) begin
                n++;
                if (n > 200) begin
                    checks++; errors++;
                    $display("FAIL send_timeout S_READY stuck low a=%0d b=%0d", $signed(a), $signed(b));
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        S_VALID = 1'b0; S_LAST = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_results(input int n, input string name);
        int t;
        t = 0;
        while (rq_data.size() < n && t < 1000) begin @(posedge clk); #1; t++; end
        checks++;
        if (rq_data.size() < n) begin
            errors++;
            $display("FAIL %s_result_count got=%0d exp=%0d", name, rq_data.size(), n);
        end
    endtask

    task automatic pop(output logic [47:0] d, output logic [7:0] c);
        if (rq_data.size() > 0) begin d = rq_data.pop_front(); c = rq_cnt.pop_front(); end
        else begin d = 'x; c = 'x; end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (S_READY !== 1'b0)     begin errors++; $display("FAIL rst_s_ready got=%b exp=0", S_READY); end
        checks++; if (R_VALID !== 1'b0)     begin errors++; $display("FAIL rst_r_valid got=%b exp=0", R_VALID); end
        checks++; if (R_DATA !== 48'd0)     begin errors++; $display("FAIL rst_r_data got=%h exp=0", R_DATA); end
        checks++; if (R_COUNT !== 8'd0)     begin errors++; $display("FAIL rst_r_count got=%0d exp=0", R_COUNT); end
        checks++; if (DSP_A !== 18'd0 || DSP_B !== 18'd0) begin errors++; $display("FAIL rst_dsp_ab got=%h/%h exp=0/0", DSP_A, DSP_B); end
        checks++; if (DSP_OPMODE !== 8'h00) begin errors++; $display("FAIL rst_opmode got=%h exp=00", DSP_OPMODE); end
        checks++; if (DSP_RST !== 1'b1)     begin errors++; $display("FAIL rst_dsp_rst got=%b exp=1", DSP_RST); end
        @(posedge clk); #1;
        RST_N = 1'b1;
        @(negedge clk);
        checks++; if (S_READY !== 1'b1 || DSP_RST !== 1'b0) begin errors++; $display("FAIL rst_release ready=%b dsp_rst=%b exp=1/0", S_READY, DSP_RST); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        logic [47:0] d; logic [7:0] c; int k;
        R_READY = 1'b1;
        send(18'd3, 18'd4, 1'b0);
        send(18'd5, -18'sd6, 1'b0);
        send(-18'sd7, 18'd8, 1'b1);
        S_VALID = 1'b0; S_LAST = 1'b0;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (R_VALID) break;
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        checks++; if (k != 4) begin errors++; $display("FAIL single_latency got=%0d exp=4", k); end
        wait_results(1, "single");
        pop(d, c);
        checks++; if (d !== 48'hFFFF_FFFF_FFB6) begin errors++; $display("FAIL single_data got=%0d exp=-74", $signed(d)); end
        checks++; if (c !== 8'd3) begin errors++; $display("FAIL single_count got=%0d exp=3", c); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] d; logic [7:0] c;
        R_READY = 1'b1;
        send(18'd2, 18'd2, 1'b1);
        send(18'd1, 18'd1, 1'b0);
        send(18'd1, 18'd1, 1'b1);
        idle(2);
        wait_results(2, "b2b");
        pop(d, c);
        checks++; if (d !== 48'd4 || c !== 8'd1) begin errors++; $display("FAIL b2b_first got=%0d/%0d exp=4/1", d, c); end
        pop(d, c);
        checks++; if (d !== 48'd2 || c !== 8'd2) begin errors++; $display("FAIL b2b_second got=%0d/%0d exp=2/2", d, c); end
    endtask

    task automatic test_bubbles();
        logic [47:0] d; logic [7:0] c;
        R_READY = 1'b1;
        send(18'd10, 18'd10, 1'b0);
        S_VALID = 1'b0;
        @(posedge clk); #1; @(negedge clk);
        checks++; if (DSP_OPMODE !== 8'h01) begin errors++; $display("FAIL bubble_opm_first got=%h exp=01", DSP_OPMODE); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (DSP_OPMODE !== 8'h08) begin errors++; $display("FAIL bubble_opm_idle1 got=%h exp=08", DSP_OPMODE); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (DSP_OPMODE !== 8'h08) begin errors++; $display("FAIL bubble_opm_idle2 got=%h exp=08", DSP_OPMODE); end
        @(posedge clk); #1;
        send(18'd1, -18'sd1, 1'b1);
        S_VALID = 1'b0;
        @(posedge clk); #1; @(negedge clk);
        checks++; if (DSP_OPMODE !== 8'h09) begin errors++; $display("FAIL bubble_opm_acc got=%h exp=09", DSP_OPMODE); end
        @(posedge clk); #1;
        wait_results(1, "bubble");
        pop(d, c);
        checks++; if (d !== 48'd99 || c !== 8'd2) begin errors++; $display("FAIL bubble_data got=%0d/%0d exp=99/2", d, c); end
    endtask

    task automatic test_backpressure();
        logic [47:0] d; logic [7:0] c;
        R_READY = 1'b0;
        for (int k = 1; k <= 4; k++) send(18'd1, 18'(k), 1'b1);
        idle(8);
        @(negedge clk);
        checks++; if (S_READY !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", S_READY); end
        checks++; if (R_VALID !== 1'b1 || R_DATA !== 48'd1) begin errors++; $display("FAIL bp_head got=%b/%0d exp=1/1", R_VALID, R_DATA); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (R_DATA !== 48'd1 || R_COUNT !== 8'd1) begin errors++; $display("FAIL bp_stable got=%0d/%0d exp=1/1", R_DATA, R_COUNT); end
        @(posedge clk); #1;
        R_READY = 1'b1;
        send(18'd1, 18'd5, 1'b1);
        send(18'd1, 18'd6, 1'b1);
        idle(2);
        wait_results(6, "bp");
        for (int k = 1; k <= 6; k++) begin
            pop(d, c);
            checks++;
            if (d !== 48'(k) || c !== 8'd1) begin errors++; $display("FAIL bp_order_%0d got=%0d/%0d exp=%0d/1", k, d, c, k); end
        end
    endtask

    task automatic test_extremes();
        logic [47:0] d; logic [7:0] c;
        R_READY = 1'b1;
        send(-18'sd131072, -18'sd131072, 1'b0);
        send(-18'sd131072, -18'sd131072, 1'b1);
        idle(2);
        wait_results(1, "ext");
        pop(d, c);
        checks++; if (d !== 48'd34359738368 || c !== 8'd2) begin errors++; $display("FAIL ext_max got=%0d/%0d exp=34359738368/2", d, c); end
    endtask

    task automatic test_count_saturate();
        logic [47:0] d; logic [7:0] c;
        R_READY = 1'b1;
        for (int i = 0; i < 299; i++) send(18'd1, 18'd1, 1'b0);
        send(18'd1, 18'd1, 1'b1);
        idle(2);
        wait_results(1, "sat");
        pop(d, c);
        checks++; if (d !== 48'd300) begin errors++; $display("FAIL sat_data got=%0d exp=300", d); end
        checks++; if (c !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", c); end
    endtask

    task automatic test_reset_midframe();
        logic [47:0] d; logic [7:0] c;
        R_READY = 1'b0;
        send(18'd3, 18'd3, 1'b1);
        idle(6);
        @(negedge clk);
        checks++; if (R_VALID !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", R_VALID); end
        @(posedge clk); #1;
        send(18'd5, 18'd5, 1'b0);
        send(18'd6, 18'd6, 1'b0);
        S_VALID = 1'b0;
        RST_N = 1'b0;
        @(negedge clk);
        checks++; if (S_READY !== 1'b0 || DSP_RST !== 1'b1) begin errors++; $display("FAIL mid_in_reset ready=%b dsp_rst=%b exp=0/1", S_READY, DSP_RST); end
        @(posedge clk); #1;
        RST_N = 1'b1;
        @(negedge clk);
        checks++; if (R_VALID !== 1'b0 || R_DATA !== 48'd0 || R_COUNT !== 8'd0) begin errors++; $display("FAIL mid_outputs got=%b/%0d/%0d exp=0/0/0", R_VALID, R_DATA, R_COUNT); end
        checks++; if (DSP_A !== 18'd0 || DSP_OPMODE !== 8'h00) begin errors++; $display("FAIL mid_dsp got=%h/%h exp=0/00", DSP_A, DSP_OPMODE); end
        @(posedge clk); #1;
        rq_data.delete(); rq_cnt.delete();
        R_READY = 1'b1;
        send(18'd2, 18'd3, 1'b1);
        idle(2);
        wait_results(1, "mid");
        pop(d, c);
        checks++; if (d !== 48'd6 || c !== 8'd1) begin errors++; $display("FAIL mid_after got=%0d/%0d exp=6/1", d, c); end
        idle(6);
        checks++; if (rq_data.size() != 0) begin errors++; $display("FAIL mid_extra got=%0d exp=0", rq_data.size()); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bubbles();
        test_backpressure();
        test_extremes();
        test_count_saturate();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
